// File: rtl/tiny_cpu_controller.sv
// rtl/tiny_cpu_controller.sv - multi-cycle control FSM for the tiny RISC datapath; `define MEM_WAIT_EN adds the mem_ready wait-state handshake with timeout
module tiny_cpu_controller #(
  parameter int WR_PULSE    = 1,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op_code,
  input  logic       run,
  input  logic       mem_ready,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       data_on_dbus,
  output logic       dbus_on_data,
  output logic       alu_on_dbus,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass,
  output logic       add,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam logic [3:0] ST_RESET     = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_LDA       = 4'd3;
  localparam logic [3:0] ST_STA_SETUP = 4'd4;
  localparam logic [3:0] ST_STA_WR    = 4'd5;
  localparam logic [3:0] ST_STA_HOLD  = 4'd6;
  localparam logic [3:0] ST_ADD       = 4'd7;
  localparam logic [3:0] ST_JMP       = 4'd8;
  localparam logic [3:0] ST_HALT      = 4'd9;

  logic [3:0] state_next;
  logic [3:0] boundary_next;
  logic [3:0] pulse_cnt;
  logic       pulse_done;
  logic       mem_ok;
  logic       timeout;

  // Last cycle of the write pulse; the counter saturates here while a wait extends STA_WR.
  assign pulse_done    = (pulse_cnt == 4'(WR_PULSE - 1));
  assign boundary_next = run ? ST_FETCH : ST_HALT;

`ifdef MEM_WAIT_EN
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       bus_err_q;

  assign mem_ok  = mem_ready;
  assign waiting = (state == ST_FETCH) || (state == ST_LDA) ||
                   ((state == ST_STA_WR) && pulse_done);
  assign timeout = waiting && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign bus_err = bus_err_q;

  // Stall counter restarts on every state change; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (waiting && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  logic [8:0] unused_cfg;

  assign unused_cfg = {mem_ready, 8'(MEM_TIMEOUT)};
  assign mem_ok     = 1'b1;
  assign timeout    = 1'b0;
  assign bus_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Write-pulse counter, zero whenever the FSM is outside STA_WR.
  always_ff @(posedge clk) begin
    if (reset || (state != ST_STA_WR)) begin
      pulse_cnt <= '0;
    end else if (!pulse_done) begin
      pulse_cnt <= pulse_cnt + 4'd1;
    end
  end

  // Next-state sequencing; run is only honoured at instruction boundaries and in HALT.
  always_comb begin
    state_next = ST_RESET;
    case (state)
      ST_RESET:     state_next = boundary_next;
      ST_FETCH:     state_next = timeout ? ST_HALT : (mem_ok ? ST_DECODE : ST_FETCH);
      ST_DECODE: begin
        case (op_code)
          2'b00:   state_next = ST_LDA;
          2'b01:   state_next = ST_STA_SETUP;
          2'b10:   state_next = ST_ADD;
          default: state_next = ST_JMP;
        endcase
      end
      ST_LDA:       state_next = timeout ? ST_HALT : (mem_ok ? boundary_next : ST_LDA);
      ST_STA_SETUP: state_next = ST_STA_WR;
      ST_STA_WR:    state_next = timeout ? ST_HALT :
                                 ((pulse_done && mem_ok) ? ST_STA_HOLD : ST_STA_WR);
      ST_STA_HOLD:  state_next = boundary_next;
      ST_ADD:       state_next = boundary_next;
      ST_JMP:       state_next = boundary_next;
      ST_HALT:      state_next = (run && !bus_err) ? ST_FETCH : ST_HALT;
      default:      state_next = ST_RESET;
    endcase
  end

  // Moore output decode; loads that capture memory data wait for mem_ok.
  always_comb begin
    ir_on_adr    = 1'b0;
    pc_on_adr    = 1'b0;
    data_on_dbus = 1'b0;
    dbus_on_data = 1'b0;
    alu_on_dbus  = 1'b0;
    ld_ir        = 1'b0;
    ld_ac        = 1'b0;
    ld_pc        = 1'b0;
    inc_pc       = 1'b0;
    clr_pc       = 1'b0;
    pass         = 1'b0;
    add          = 1'b0;
    rd_mem       = 1'b0;
    wr_mem       = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_RESET: clr_pc = 1'b1;
      ST_FETCH: begin
        pc_on_adr    = 1'b1;
        rd_mem       = 1'b1;
        data_on_dbus = 1'b1;
        ld_ir        = mem_ok;
        inc_pc       = mem_ok;
      end
      ST_LDA: begin
        ir_on_adr    = 1'b1;
        rd_mem       = 1'b1;
        data_on_dbus = 1'b1;
        ld_ac        = mem_ok;
        instr_done   = mem_ok;
      end
      ST_STA_SETUP, ST_STA_WR, ST_STA_HOLD: begin
        ir_on_adr    = 1'b1;
        pass         = 1'b1;
        alu_on_dbus  = 1'b1;
        dbus_on_data = 1'b1;
        wr_mem       = (state == ST_STA_WR);
        instr_done   = (state == ST_STA_HOLD);
      end
      ST_ADD: begin
        add         = 1'b1;
        alu_on_dbus = 1'b1;
        ld_ac       = 1'b1;
        instr_done  = 1'b1;
      end
      ST_JMP: begin
        ld_pc      = 1'b1;
        instr_done = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_tiny_cpu_controller.sv
// tb/tb_tiny_cpu_controller.sv - randomized check of tiny_cpu_controller against an instruction-level model
module tb_tiny_cpu_controller;

  localparam int WR_PULSE    = 3;
  localparam int MEM_TIMEOUT = 8;

  localparam logic [15:0] C_IR_ADR    = 16'h8000;
  localparam logic [15:0] C_PC_ADR    = 16'h4000;
  localparam logic [15:0] C_DATA_DBUS = 16'h2000;
  localparam logic [15:0] C_DBUS_DATA = 16'h1000;
  localparam logic [15:0] C_ALU_DBUS  = 16'h0800;
  localparam logic [15:0] C_LD_IR     = 16'h0400;
  localparam logic [15:0] C_LD_AC     = 16'h0200;
  localparam logic [15:0] C_LD_PC     = 16'h0100;
  localparam logic [15:0] C_INC_PC    = 16'h0080;
  localparam logic [15:0] C_CLR_PC    = 16'h0040;
  localparam logic [15:0] C_PASS      = 16'h0020;
  localparam logic [15:0] C_ADD       = 16'h0010;
  localparam logic [15:0] C_RD        = 16'h0008;
  localparam logic [15:0] C_WR        = 16'h0004;
  localparam logic [15:0] C_DONE      = 16'h0002;
  localparam logic [15:0] C_HALTED    = 16'h0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       mem_ready;
  logic [1:0] op_code;
  logic       ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus;
  logic       ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add;
  logic       rd_mem, wr_mem, instr_done, halted, bus_err;
  logic [3:0] state;
  logic [15:0] ctl;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [3:0] exp_state;
  int         plan[$];

  always #5 clk = ~clk;

  tiny_cpu_controller #(.WR_PULSE(WR_PULSE), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .run(run), .mem_ready(mem_ready),
    .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .data_on_dbus(data_on_dbus),
    .dbus_on_data(dbus_on_data), .alu_on_dbus(alu_on_dbus), .ld_ir(ld_ir),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc), .pass(pass),
    .add(add), .rd_mem(rd_mem), .wr_mem(wr_mem), .instr_done(instr_done),
    .halted(halted), .bus_err(bus_err), .state(state)
  );

  assign ctl = {ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus,
                ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add,
                rd_mem, wr_mem, instr_done, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Control lines each state must show, straight from the state table.
  function automatic logic [15:0] exp_ctl(input logic [3:0] s);
    logic [15:0] sta;
    sta = C_IR_ADR | C_PASS | C_ALU_DBUS | C_DBUS_DATA;
    case (s)
      4'd0:    return C_CLR_PC;
      4'd1:    return C_PC_ADR | C_RD | C_DATA_DBUS | C_LD_IR | C_INC_PC;
      4'd2:    return 16'h0000;
      4'd3:    return C_IR_ADR | C_RD | C_DATA_DBUS | C_LD_AC | C_DONE;
      4'd4:    return sta;
      4'd5:    return sta | C_WR;
      4'd6:    return sta | C_DONE;
      4'd7:    return C_ADD | C_ALU_DBUS | C_LD_AC | C_DONE;
      4'd8:    return C_LD_PC | C_DONE;
      4'd9:    return C_HALTED;
      default: return 16'hffff;
    endcase
  endfunction

  // Check the current cycle, apply inputs for the next edge, advance the instruction plan.
  task automatic cycle(input logic rst, input logic r, input logic [1:0] op);
    check("state", 32'(state), 32'(exp_state));
    check("ctl", 32'(ctl), 32'(exp_ctl(exp_state)));
    check("bus_err", 32'(bus_err), 32'd0);
    check("contention", {29'd0, ir_on_adr & pc_on_adr, data_on_dbus & alu_on_dbus,
                         rd_mem & wr_mem}, 32'd0);
    reset   = rst;
    run     = r;
    op_code = op;
    if (rst) begin
      plan.delete();
      exp_state = 4'd0;
    end else begin
      if (exp_state == 4'd2) begin
        case (op)
          2'b00: plan.push_back(3);
          2'b01: begin
            plan.push_back(4);
            for (int i = 0; i < WR_PULSE; i++) plan.push_back(5);
            plan.push_back(6);
          end
          2'b10: plan.push_back(7);
          default: plan.push_back(8);
        endcase
      end
      if (plan.size() > 0) begin
        exp_state = 4'(plan.pop_front());
      end else if (r) begin
        exp_state = 4'd1;
        plan.push_back(2);
      end else begin
        exp_state = 4'd9;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic       rr;
    logic       rs;
    logic [1:0] ro;
    reset     = 1'b1;
    run       = 1'b0;
    op_code   = 2'b00;
    mem_ready = 1'b1;
    @(negedge clk);
    exp_state = 4'd0;

    cycle(1'b1, 1'b0, 2'b00);
    cycle(1'b1, 1'b1, 2'b10);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'b10);
    for (int i = 0; i < 10; i++) cycle(1'b0, (i < 3) || (i > 7), 2'b01);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b11);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b00);
    cycle(1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 2'b00);

    for (int i = 0; i < 800; i++) begin
      rs = ($urandom_range(0, 63) == 0);
      rr = ($urandom_range(0, 7) != 0);
      ro = 2'($urandom_range(0, 3));
      cycle(rs, rr, ro);
    end

`ifdef MEM_WAIT_EN
    begin
      int n;
      reset = 1'b1;
      run   = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("stall_state", 32'(state), 32'd1);
        check("stall_ld_ir", 32'(ld_ir), 32'd0);
        @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      check("ready_ld_ir", 32'(ld_ir), 32'd1);
      check("ready_inc_pc", 32'(inc_pc), 32'd1);
      @(negedge clk);
      check("ready_decode", 32'(state), 32'd2);

      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      n = 0;
      while (state == 4'd1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      check("timeout_cycles", 32'(n), 32'(MEM_TIMEOUT));
      check("timeout_state", 32'(state), 32'd9);
      check("timeout_bus_err", 32'(bus_err), 32'd1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("err_stays_halt", 32'(state), 32'd9);
      end
      reset = 1'b1;
      @(negedge clk);
      check("reset_clears_err", 32'(bus_err), 32'd0);
      check("reset_state", 32'(state), 32'd0);
      reset     = 1'b0;
      mem_ready = 1'b1;
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
